// File: rtl/tetris_pkg.sv
// Shared encodings for the falling-piece controller: piece types, the
// controller state enum, the probe-purpose tag and the rotation kick table.
package tetris_pkg;

  typedef enum logic [2:0] {
    PC_I = 3'd0,
    PC_O = 3'd1,
    PC_T = 3'd2,
    PC_S = 3'd3,
    PC_Z = 3'd4,
    PC_J = 3'd5,
    PC_L = 3'd6
  } piece_e;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SPAWN,
    ST_PLAY,
    ST_PROBE,
    ST_LOCK,
    ST_NEWP,
    ST_OVER
  } state_e;

  // Why a probe is in flight; selects what a pass/hit response does.
  typedef enum logic [2:0] {
    PK_SPAWN,
    PK_GRAV,
    PK_MOVE,
    PK_ROT,
    PK_DROP
  } probe_e;

  localparam logic [1:0] KICK_LAST = 2'd3;

  // Wall-kick x offsets, tried in order 0, -1, +1, -2.
  function automatic logic signed [2:0] kick_off(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'sb000;
      2'd1:    return 3'sb111;
      2'd2:    return 3'sb001;
      default: return 3'sb110;
    endcase
  endfunction

  // Random source yields 0..7; 7 has no piece and folds onto I.
  function automatic logic [2:0] blk_fix(input logic [2:0] b);
    return (b == 3'd7) ? 3'(PC_I) : b;
  endfunction

  function automatic logic [2:0] blk_succ(input logic [2:0] b);
    logic [2:0] f;
    f = blk_fix(b);
    return (f == 3'(PC_L)) ? 3'(PC_I) : f + 3'd1;
  endfunction

endpackage

// File: rtl/auto_repeat.sv
// Held-button auto-repeat: one step on press, another after DAS_DELAY
// ticks, then one every ARR ticks while the button stays held.
module auto_repeat #(
  parameter int unsigned DAS_DELAY = 170,
  parameter int unsigned ARR       = 50
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  input  logic inhibit,
  output logic step
);

  localparam logic [15:0] DAS_C = 16'(DAS_DELAY);
  localparam logic [15:0] ARR_C = 16'(ARR);

  logic        btn_q;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        rep_q, rep_d;

  // Press detection and DAS/ARR tick counting.
  always_comb begin
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    step    = 1'b0;
    cnt_inc = cnt_q + 16'd1;
    if (inhibit || !btn) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!btn_q) begin
      step  = 1'b1;
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (tick) begin
      if (cnt_inc >= (rep_q ? ARR_C : DAS_C)) begin
        step  = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Button history and repeat counter registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      btn_q <= btn;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/piece_ctl_gen.sv
// Falling-piece controller: owns the active piece, proposes candidate
// moves to the board collision checker and commits those that pass.
module piece_ctl_gen
  import tetris_pkg::*;
#(
  parameter int unsigned COLS          = 10,
  parameter int unsigned ROWS          = 20,
  parameter int unsigned XW            = 5,
  parameter int unsigned YW            = 5,
  parameter int unsigned SPAWN_X       = 4,
  parameter int unsigned BASE_DELAY    = 1000,
  parameter int unsigned LEVEL_STEP    = 100,
  parameter int unsigned MIN_DELAY     = 50,
  parameter int unsigned SOFT_DIV_LOG2 = 3,
  parameter int unsigned DAS_DELAY     = 170,
  parameter int unsigned ARR           = 50
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic [3:0]    level,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          btn_d,
  input  logic          btn_u,
  input  logic          btn_drop,
  input  logic          btn_hold,
  input  logic [2:0]    rand_blk,
  output logic          chk_req,
  output logic [XW-1:0] chk_x,
  output logic [YW-1:0] chk_y,
  output logic [1:0]    chk_rot,
  output logic [2:0]    chk_blk,
  input  logic          chk_ack,
  input  logic          chk_hit,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic [1:0]    rot,
  output logic [2:0]    block,
  output logic [2:0]    next_block,
  output logic [2:0]    hold_block,
  output logic          hold_valid,
  output logic          lock_en,
  output logic          game_over
);

  localparam logic [XW-1:0] SPAWN_XV = XW'(SPAWN_X);
  localparam logic [XW-1:0] COLS_V   = XW'(COLS);
  localparam logic [YW-1:0] ROWS_V   = YW'(ROWS);
  localparam logic [XW-1:0] ONE_X    = XW'(1);
  localparam logic [YW-1:0] ONE_Y    = YW'(1);

  state_e        state_q, state_d;
  probe_e        kind_q, kind_d;
  logic [1:0]    kick_q, kick_d, kick_nxt;
  logic [XW-1:0] x_q, x_d, cx_q, cx_d, kick_x;
  logic [YW-1:0] y_q, y_d, cy_q, cy_d;
  logic [1:0]    rot_q, rot_d, crot_q, crot_d;
  logic [2:0]    blk_q, blk_d, next_q, next_d, hold_q, hold_d;
  logic          hold_v_q, hold_v_d, used_q, used_d;
  logic [31:0]   grav_q, grav_d;
  logic          pl_q, pl_d, pr_q, pr_d, pu_q, pu_d, pdrop_q, pdrop_d, phold_q, phold_d;
  logic          u_prev_q, drop_prev_q, hold_prev_q;
  logic          ev_u, ev_drop, ev_hold, step_l, step_r, both_lr;
  logic          eff_l, eff_r, eff_u, eff_drop, eff_hold;
  logic          latch_en, hit_eff, grav_due;
  logic signed [2:0] kval;
  logic [31:0]   lvl_red, per_full, per_soft, per_eff;

  assign ev_u    = btn_u & ~u_prev_q;
  assign ev_drop = btn_drop & ~drop_prev_q;
  assign ev_hold = btn_hold & ~hold_prev_q;
  assign both_lr = btn_l & btn_r;

  auto_repeat #(.DAS_DELAY(DAS_DELAY), .ARR(ARR)) u_rep_l (
    .pclk(pclk), .rst_n(rst_n), .tick(tick), .btn(btn_l), .inhibit(both_lr), .step(step_l)
  );

  auto_repeat #(.DAS_DELAY(DAS_DELAY), .ARR(ARR)) u_rep_r (
    .pclk(pclk), .rst_n(rst_n), .tick(tick), .btn(btn_r), .inhibit(both_lr), .step(step_r)
  );

  // Gravity period from level, clamped at the floor without underflow.
  always_comb begin
    lvl_red = LEVEL_STEP * {28'd0, level};
    if (BASE_DELAY > lvl_red + MIN_DELAY) per_full = BASE_DELAY - lvl_red;
    else                                  per_full = MIN_DELAY;
    per_soft = per_full >> SOFT_DIV_LOG2;
    if (per_soft == '0) per_soft = 32'd1;
    per_eff = btn_d ? per_soft : per_full;
  end

  // A candidate outside the board can never be committed, even if the
  // checker were to pass it.
  assign hit_eff  = chk_hit | (cx_q >= COLS_V) | (cy_q >= ROWS_V);
  assign grav_due = (grav_q >= per_eff);
  assign kick_nxt = kick_q + 2'd1;
  assign kval     = kick_off(kick_nxt);
  assign kick_x   = x_q + {{(XW-3){kval[2]}}, kval};

  // Action arbitration, probe sequencing and next-state logic.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    kick_d   = kick_q;
    x_d      = x_q;
    y_d      = y_q;
    rot_d    = rot_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    crot_d   = crot_q;
    blk_d    = blk_q;
    next_d   = next_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    used_d   = used_q;
    grav_d   = grav_q;

    latch_en = (state_q == ST_PLAY) || (state_q == ST_PROBE && kind_q != PK_DROP);
    eff_l    = pl_q | step_l;
    eff_r    = pr_q | step_r;
    eff_u    = pu_q | ev_u;
    eff_drop = pdrop_q | ev_drop;
    eff_hold = phold_q | (ev_hold & ~used_q);

    if (latch_en) begin
      pl_d    = eff_l;
      pr_d    = eff_r;
      pu_d    = eff_u;
      pdrop_d = eff_drop;
      phold_d = eff_hold;
    end else begin
      pl_d    = 1'b0;
      pr_d    = 1'b0;
      pu_d    = 1'b0;
      pdrop_d = 1'b0;
      phold_d = 1'b0;
    end

    if (tick && grav_q != '1 &&
        (state_q == ST_PLAY || (state_q == ST_PROBE && kind_q != PK_SPAWN)))
      grav_d = grav_q + 32'd1;

    case (state_q)
      ST_WAIT: begin
        if (start) begin
          blk_d   = blk_fix(rand_blk);
          next_d  = blk_succ(rand_blk);
          state_d = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        x_d     = SPAWN_XV;
        y_d     = '0;
        rot_d   = '0;
        cx_d    = SPAWN_XV;
        cy_d    = '0;
        crot_d  = '0;
        grav_d  = '0;
        kind_d  = PK_SPAWN;
        state_d = ST_PROBE;
      end
      ST_PLAY: begin
        if (eff_drop) begin
          pl_d    = 1'b0;
          pr_d    = 1'b0;
          pu_d    = 1'b0;
          pdrop_d = 1'b0;
          phold_d = 1'b0;
          cx_d    = x_q;
          cy_d    = y_q + ONE_Y;
          crot_d  = rot_q;
          kind_d  = PK_DROP;
          state_d = ST_PROBE;
        end else if (eff_hold) begin
          phold_d = 1'b0;
          used_d  = 1'b1;
          hold_d  = blk_q;
          if (hold_v_q) begin
            blk_d   = hold_q;
            state_d = ST_SPAWN;
          end else begin
            hold_v_d = 1'b1;
            state_d  = ST_NEWP;
          end
        end else if (grav_due) begin
          cx_d    = x_q;
          cy_d    = y_q + ONE_Y;
          crot_d  = rot_q;
          kind_d  = PK_GRAV;
          state_d = ST_PROBE;
        end else if (eff_u) begin
          pu_d    = 1'b0;
          kick_d  = '0;
          cx_d    = x_q;
          cy_d    = y_q;
          crot_d  = rot_q + 2'd1;
          kind_d  = PK_ROT;
          state_d = ST_PROBE;
        end else if (eff_l) begin
          pl_d    = 1'b0;
          cx_d    = x_q - ONE_X;
          cy_d    = y_q;
          crot_d  = rot_q;
          kind_d  = PK_MOVE;
          state_d = ST_PROBE;
        end else if (eff_r) begin
          pr_d    = 1'b0;
          cx_d    = x_q + ONE_X;
          cy_d    = y_q;
          crot_d  = rot_q;
          kind_d  = PK_MOVE;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (chk_ack) begin
          case (kind_q)
            PK_SPAWN: state_d = hit_eff ? ST_OVER : ST_PLAY;
            PK_GRAV: begin
              if (hit_eff) begin
                state_d = ST_LOCK;
              end else begin
                y_d     = cy_q;
                grav_d  = '0;
                state_d = ST_PLAY;
              end
            end
            PK_MOVE: begin
              if (!hit_eff) x_d = cx_q;
              state_d = ST_PLAY;
            end
            PK_ROT: begin
              if (!hit_eff) begin
                x_d     = cx_q;
                rot_d   = crot_q;
                state_d = ST_PLAY;
              end else if (kick_q != KICK_LAST) begin
                kick_d = kick_nxt;
                cx_d   = kick_x;
              end else begin
                state_d = ST_PLAY;
              end
            end
            PK_DROP: begin
              if (hit_eff) begin
                state_d = ST_LOCK;
              end else begin
                y_d  = cy_q;
                cy_d = cy_q + ONE_Y;
              end
            end
            default: state_d = ST_PLAY;
          endcase
        end
      end
      ST_LOCK: begin
        // Hold-used is released here rather than in NEWP so that the
        // hold-into-empty-slot path (which also passes through NEWP)
        // keeps the new piece from being held again.
        used_d  = 1'b0;
        state_d = ST_NEWP;
      end
      ST_NEWP: begin
        blk_d   = next_q;
        next_d  = blk_fix(rand_blk);
        state_d = ST_SPAWN;
      end
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Controller state, piece registers and pending-event latches.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      kind_q      <= PK_SPAWN;
      kick_q      <= '0;
      x_q         <= SPAWN_XV;
      y_q         <= '0;
      rot_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      crot_q      <= '0;
      blk_q       <= '0;
      next_q      <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      used_q      <= 1'b0;
      grav_q      <= '0;
      pl_q        <= 1'b0;
      pr_q        <= 1'b0;
      pu_q        <= 1'b0;
      pdrop_q     <= 1'b0;
      phold_q     <= 1'b0;
      u_prev_q    <= 1'b0;
      drop_prev_q <= 1'b0;
      hold_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      kick_q      <= kick_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rot_q       <= rot_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      crot_q      <= crot_d;
      blk_q       <= blk_d;
      next_q      <= next_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      used_q      <= used_d;
      grav_q      <= grav_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      pu_q        <= pu_d;
      pdrop_q     <= pdrop_d;
      phold_q     <= phold_d;
      u_prev_q    <= btn_u;
      drop_prev_q <= btn_drop;
      hold_prev_q <= btn_hold;
    end
  end

  assign chk_req    = (state_q == ST_PROBE);
  assign chk_x      = cx_q;
  assign chk_y      = cy_q;
  assign chk_rot    = crot_q;
  assign chk_blk    = blk_q;
  assign xpos       = x_q;
  assign ypos       = y_q;
  assign rot        = rot_q;
  assign block      = blk_q;
  assign next_block = next_q;
  assign hold_block = hold_q;
  assign hold_valid = hold_v_q;
  assign lock_en    = (state_q == ST_LOCK);
  assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_piece_ctl_gen.sv
// Directed bench for piece_ctl_gen with a behavioural collision checker.
module tb_piece_ctl_gen;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] level = 4'd0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_d = 1'b0, btn_u = 1'b0;
  logic       btn_drop = 1'b0, btn_hold = 1'b0;
  logic [2:0] rand_blk = 3'd0;
  logic       chk_req;
  logic [4:0] chk_x, chk_y;
  logic [1:0] chk_rot;
  logic [2:0] chk_blk;
  logic       chk_ack = 1'b0, chk_hit = 1'b0;
  logic [4:0] xpos, ypos;
  logic [1:0] rot;
  logic [2:0] block, next_block, hold_block;
  logic       hold_valid, lock_en, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // checker model controls and observations
  int         hit_mode = 0;   // 0 pass, 1 hit, 2 hit at y>=floor_y, 3 column 0 blocked
  logic [4:0] floor_y  = 5'd31;
  bit         stall    = 1'b0;
  int         probe_cnt = 0;
  int         lock_cnt  = 0;
  logic [4:0] last_y    = '0;
  logic [4:0] y_at_lock = '0;
  int         p0;

  piece_ctl_gen #(
    .COLS(10), .ROWS(20), .XW(5), .YW(5), .SPAWN_X(4),
    .BASE_DELAY(1000), .LEVEL_STEP(100), .MIN_DELAY(50),
    .SOFT_DIV_LOG2(3), .DAS_DELAY(170), .ARR(50)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .tick(tick), .start(start), .level(level),
    .btn_l(btn_l), .btn_r(btn_r), .btn_d(btn_d), .btn_u(btn_u),
    .btn_drop(btn_drop), .btn_hold(btn_hold), .rand_blk(rand_blk),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
    .chk_blk(chk_blk), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .xpos(xpos), .ypos(ypos), .rot(rot), .block(block),
    .next_block(next_block), .hold_block(hold_block), .hold_valid(hold_valid),
    .lock_en(lock_en), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  function automatic logic model_hit(input logic [4:0] x, input logic [4:0] y);
    if (x >= 5'd10 || y >= 5'd20) return 1'b1;
    case (hit_mode)
      1:       return 1'b1;
      2:       return (y >= floor_y);
      3:       return (x == 5'd0);
      default: return 1'b0;
    endcase
  endfunction

  // Collision checker: answers each request one half-cycle later with a
  // single-cycle ack; also tallies lock pulses.
  always @(negedge pclk) begin
    if (!rst_n) begin
      chk_ack = 1'b0;
      chk_hit = 1'b0;
    end else begin
      if (chk_ack) begin
        chk_ack = 1'b0;
      end else if (chk_req && !stall) begin
        chk_hit = model_hit(chk_x, chk_y);
        chk_ack = 1'b1;
        probe_cnt++;
        last_y = chk_y;
      end
      if (lock_en) begin
        lock_cnt++;
        y_at_lock = ypos;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cyc(3);
    check_val("rst_xpos", 32'(xpos), 32'd4);
    check_val("rst_ypos", 32'(ypos), 32'd0);
    check_val("rst_block", 32'(block), 32'd0);
    check_val("rst_req", 32'(chk_req), 32'd0);
    check_val("rst_over", 32'(game_over), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // start and spawn
    rand_blk = 3'd2;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    check_val("spawn_block", 32'(block), 32'd2);
    check_val("spawn_next", 32'(next_block), 32'd3);
    check_val("spawn_xpos", 32'(xpos), 32'd4);
    check_val("spawn_ypos", 32'(ypos), 32'd0);
    check_val("spawn_probes", 32'(probe_cnt), 32'd1);

    // gravity at level 3: period 700 ticks
    level = 4'd3;
    p0 = probe_cnt;
    pulse_tick(699);
    cyc(4);
    check_val("grav_699", 32'(probe_cnt), 32'(p0));
    pulse_tick(1);
    cyc(4);
    check_val("grav_700", 32'(probe_cnt), 32'(p0 + 1));
    check_val("grav_ylast", 32'(last_y), 32'd1);
    check_val("grav_ypos", 32'(ypos), 32'd1);

    // auto-repeat right
    btn_r = 1'b1;
    cyc(4);
    check_val("das_press", 32'(xpos), 32'd5);
    pulse_tick(169);
    cyc(2);
    check_val("das_169", 32'(xpos), 32'd5);
    pulse_tick(1);
    cyc(4);
    check_val("das_170", 32'(xpos), 32'd6);
    pulse_tick(49);
    cyc(2);
    check_val("arr_49", 32'(xpos), 32'd6);
    pulse_tick(1);
    cyc(4);
    check_val("arr_50", 32'(xpos), 32'd7);
    pulse_tick(50);
    cyc(4);
    check_val("arr_100", 32'(xpos), 32'd8);
    btn_r = 1'b0;
    cyc(2);

    // walk to the left wall, then push into it
    for (int i = 0; i < 9; i++) begin
      btn_l = 1'b1;
      cyc(1);
      btn_l = 1'b0;
      cyc(6);
    end
    check_val("left_wall_x", 32'(xpos), 32'd0);

    // rotate with offsets 0 and -1 blocked
    hit_mode = 3;
    p0 = probe_cnt;
    btn_u = 1'b1;
    cyc(1);
    btn_u = 1'b0;
    cyc(20);
    check_val("kick_x", 32'(xpos), 32'd1);
    check_val("kick_rot", 32'(rot), 32'd1);
    check_val("kick_probes", 32'(probe_cnt), 32'(p0 + 3));

    // rotate with every kick blocked
    hit_mode = 1;
    p0 = probe_cnt;
    btn_u = 1'b1;
    cyc(1);
    btn_u = 1'b0;
    cyc(25);
    check_val("kickfail_x", 32'(xpos), 32'd1);
    check_val("kickfail_rot", 32'(rot), 32'd1);
    check_val("kickfail_probes", 32'(probe_cnt), 32'(p0 + 4));

    // hold into empty slot, then a second press on the same piece
    hit_mode = 0;
    rand_blk = 3'd5;
    btn_hold = 1'b1;
    cyc(1);
    btn_hold = 1'b0;
    cyc(10);
    check_val("hold1_valid", 32'(hold_valid), 32'd1);
    check_val("hold1_hblk", 32'(hold_block), 32'd2);
    check_val("hold1_block", 32'(block), 32'd3);
    check_val("hold1_next", 32'(next_block), 32'd5);
    check_val("hold1_xpos", 32'(xpos), 32'd4);
    p0 = probe_cnt;
    btn_hold = 1'b1;
    cyc(1);
    btn_hold = 1'b0;
    cyc(10);
    check_val("hold2_block", 32'(block), 32'd3);
    check_val("hold2_hblk", 32'(hold_block), 32'd2);
    check_val("hold2_probes", 32'(probe_cnt), 32'(p0));

    // hard drop onto a floor at row 18
    hit_mode = 2;
    floor_y = 5'd18;
    rand_blk = 3'd6;
    btn_drop = 1'b1;
    cyc(1);
    btn_drop = 1'b0;
    cyc(120);
    check_val("drop_ylock", 32'(y_at_lock), 32'd17);
    check_val("drop_locks", 32'(lock_cnt), 32'd1);
    check_val("drop_block", 32'(block), 32'd5);
    check_val("drop_next", 32'(next_block), 32'd6);
    check_val("drop_respawn_y", 32'(ypos), 32'd0);

    // hold is available again on the new piece: swap with the slot
    btn_hold = 1'b1;
    cyc(1);
    btn_hold = 1'b0;
    cyc(10);
    check_val("swap_block", 32'(block), 32'd2);
    check_val("swap_hblk", 32'(hold_block), 32'd5);

    // soft drop at level 3: period 87 ticks
    hit_mode = 0;
    btn_d = 1'b1;
    p0 = probe_cnt;
    pulse_tick(86);
    cyc(2);
    check_val("soft_86", 32'(probe_cnt), 32'(p0));
    pulse_tick(1);
    cyc(4);
    check_val("soft_87_y", 32'(ypos), 32'd1);
    btn_d = 1'b0;

    // level 15 floors at 50 ticks; everything hits -> lock then game over
    level = 4'd15;
    hit_mode = 1;
    pulse_tick(50);
    cyc(20);
    check_val("over_flag", 32'(game_over), 32'd1);
    check_val("over_locks", 32'(lock_cnt), 32'd2);
    p0 = probe_cnt;
    pulse_tick(60);
    btn_u = 1'b1;
    cyc(1);
    btn_u = 1'b0;
    cyc(10);
    check_val("over_sticky", 32'(game_over), 32'd1);
    check_val("over_noreq", 32'(chk_req), 32'd0);
    check_val("over_noprobe", 32'(probe_cnt), 32'(p0));

    // reset in the middle of a stalled spawn probe
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    hit_mode = 0;
    stall = 1'b1;
    rand_blk = 3'd6;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    check_val("stall_req", 32'(chk_req), 32'd1);
    check_val("stall_chkx", 32'(chk_x), 32'd4);
    check_val("stall_block", 32'(block), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_req", 32'(chk_req), 32'd0);
    check_val("arst_block", 32'(block), 32'd0);
    check_val("arst_xpos", 32'(xpos), 32'd4);
    check_val("arst_over", 32'(game_over), 32'd0);
    stall = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // rand_blk=7 folds onto piece 0
    rand_blk = 3'd7;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    check_val("r7_block", 32'(block), 32'd0);
    check_val("r7_next", 32'(next_block), 32'd1);
    check_val("r7_req", 32'(chk_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
